// File: rtl/switch_io_pkg.sv
// Shared types and constants for the switch I/O controller.
// SWSR bit positions, bus width and debounce FSM states.
package switch_io_pkg;

  localparam int IO_W = 16;

  localparam int RDY = 15;
  localparam int IE  = 14;
  localparam int OVR = 13;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMMIT
  } state_t;

endpackage

// File: rtl/switch_io_ctrl_if.sv
// CPU-side register bus of the switch controller.
// master = CPU, slave = controller.
interface switch_io_ctrl_if;
  import switch_io_pkg::*;

  logic            rd_dr;
  logic            wr_sr;
  logic [IO_W-1:0] wr_data;
  logic [IO_W-1:0] swsr;
  logic [IO_W-1:0] swdr;
  logic            irq;

  modport master (
    output rd_dr,
    output wr_sr,
    output wr_data,
    input  swsr,
    input  swdr,
    input  irq
  );

  modport slave (
    input  rd_dr,
    input  wr_sr,
    input  wr_data,
    output swsr,
    output swdr,
    output irq
  );

endinterface

// File: rtl/switch_io_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// q lags d by two clock edges.
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/switch_io_ctrl.sv
// Debounced switch register (SWDR) with KBSR-style status (SWSR).
// Define SW_IRQ_EN to enable the IE bit and the irq output.
module switch_io_ctrl
  import switch_io_pkg::*;
#(
  parameter int SW_W         = 8,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW_W-1:0] sw,
  switch_io_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYC - 1);

  logic [SW_W-1:0]  s2;
  logic [SW_W-1:0]  stable;
  logic [SW_W-1:0]  cand;
  logic [SW_W-1:0]  cand_n;
  logic [SW_W-1:0]  data;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             ready;
  logic             ovr;
  logic             ie_bit;
  logic             commit;
  state_t           state;
  state_t           state_n;

  sync_2ff #(
    .W (SW_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw),
    .q     (s2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  // A change of s2 during SETTLE restarts the hold timer.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2 != stable) begin
          state_n = SETTLE;
          cand_n  = s2;
          cnt_n   = '0;
        end
      end
      SETTLE: begin
        if (s2 == stable) begin
          state_n = IDLE;
        end else if (s2 != cand) begin
          cand_n = s2;
          cnt_n  = '0;
        end else if (cnt == LAST) begin
          state_n = COMMIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A commit outranks a simultaneous read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
      data   <= '0;
      ready  <= 1'b0;
      ovr    <= 1'b0;
    end else if (commit) begin
      stable <= cand;
      data   <= cand;
      ready  <= 1'b1;
      ovr    <= ovr | (ready & ~bus.rd_dr);
    end else if (bus.rd_dr) begin
      ready <= 1'b0;
      ovr   <= 1'b0;
    end
  end

`ifdef SW_IRQ_EN
  logic ie;
  logic irq_q;
  logic [IO_W-2:0] unused_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (bus.wr_sr) begin
        ie <= bus.wr_data[IE];
      end
      irq_q <= ready & ie;
    end
  end

  assign ie_bit    = ie;
  assign bus.irq   = irq_q;
  assign unused_wr = {bus.wr_data[IO_W-1:IE+1],
                      bus.wr_data[IE-1:0]};
`else
  logic [IO_W:0] unused_wr;

  assign ie_bit    = 1'b0;
  assign bus.irq   = 1'b0;
  assign unused_wr = {bus.wr_sr, bus.wr_data};
`endif

  always_comb begin
    bus.swsr      = '0;
    bus.swsr[RDY] = ready;
    bus.swsr[IE]  = ie_bit;
    bus.swsr[OVR] = ovr;
  end

  assign bus.swdr = IO_W'(data);

endmodule

// File: tb/tb_switch_io_ctrl.sv
// Directed bench for switch_io_ctrl with a commit scoreboard.
// Compile with SW_IRQ_EN to cover the interrupt path.
module tb_switch_io_ctrl;
  import switch_io_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  int         total = 0;
  int         bad   = 0;
  logic [15:0] q[$];

  switch_io_ctrl_if bus ();

  switch_io_ctrl #(
    .SW_W         (8),
    .DEBOUNCE_CYC (DEB),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic read_pulse();
    bus.rd_dr = 1'b1;
    step(1);
    bus.rd_dr = 1'b0;
  endtask

  // Waits for swdr to change, then scores it.
  task automatic wait_commit(input string tag,
                             input int budget);
    logic [15:0] prev;
    logic [15:0] exp;
    int n;
    prev = bus.swdr;
    n = 0;
    while (bus.swdr === prev && n < budget) begin
      step(1);
      n++;
    end
    total++;
    assert (bus.swdr !== prev) else begin
      bad++;
      $error("FAIL %s_timeout observed=%h expected=change",
             tag, bus.swdr);
    end
    exp = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
    check(tag, {16'h0, bus.swdr}, {16'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    sw           = 8'hA5;
    bus.rd_dr    = 1'b0;
    bus.wr_sr    = 1'b0;
    bus.wr_data  = 16'h0;
    step(3);
    check("rst_swdr", {16'h0, bus.swdr}, 32'h0);
    check("rst_swsr", {16'h0, bus.swsr}, 32'h0);
    check("rst_irq", {31'h0, bus.irq}, 32'h0);

    // 1: reset release with A5 already on the switches
    rst_n = 1'b1;
    q.push_back(16'h00A5);
    step(7);
    check("t1_early_rdy", {31'h0, bus.swsr[RDY]}, 32'h0);
    step(1);
    check("t1_swdr", {16'h0, bus.swdr}, {16'h0, q.pop_front()});
    check("t1_rdy", {31'h0, bus.swsr[RDY]}, 32'h1);
    check("t1_ovr", {31'h0, bus.swsr[OVR]}, 32'h0);
    read_pulse();
    check("t1_rd_rdy", {31'h0, bus.swsr[RDY]}, 32'h0);
    check("t1_rd_swdr", {16'h0, bus.swdr}, 32'h00A5);

    // 2: three-cycle glitch is rejected
    sw = 8'h00;
    q.push_back(16'h0000);
    wait_commit("t2_zero", 30);
    read_pulse();
    sw = 8'h01;
    step(3);
    sw = 8'h00;
    step(20);
    check("t2_glitch_swdr", {16'h0, bus.swdr}, 32'h0);
    check("t2_glitch_rdy", {31'h0, bus.swsr[RDY]}, 32'h0);

    // 3: late change restarts the timer
    sw = 8'h0F;
    step(4);
    sw = 8'hF0;
    q.push_back(16'h00F0);
    wait_commit("t3_f0", 30);
    step(20);
    check("t3_hold", {16'h0, bus.swdr}, 32'h00F0);
    read_pulse();

    // 4: overrun on an unread commit
    sw = 8'h11;
    q.push_back(16'h0011);
    wait_commit("t4_11", 30);
    check("t4_ovr0", {31'h0, bus.swsr[OVR]}, 32'h0);
    sw = 8'h22;
    q.push_back(16'h0022);
    wait_commit("t4_22", 30);
    check("t4_rdy", {31'h0, bus.swsr[RDY]}, 32'h1);
    check("t4_ovr1", {31'h0, bus.swsr[OVR]}, 32'h1);
    read_pulse();
    check("t4_rd_rdy", {31'h0, bus.swsr[RDY]}, 32'h0);
    check("t4_rd_ovr", {31'h0, bus.swsr[OVR]}, 32'h0);

    // 5: read in the commit cycle while READY is already set
    sw = 8'h44;
    q.push_back(16'h0044);
    wait_commit("t5_44", 30);
    sw = 8'h33;
    step(7);
    check("t5_pre_swdr", {16'h0, bus.swdr}, 32'h0044);
    bus.rd_dr = 1'b1;
    step(1);
    bus.rd_dr = 1'b0;
    check("t5_swdr", {16'h0, bus.swdr}, 32'h0033);
    check("t5_rdy", {31'h0, bus.swsr[RDY]}, 32'h1);
    check("t5_ovr", {31'h0, bus.swsr[OVR]}, 32'h0);
    read_pulse();

    // reset in the middle of SETTLE drops the candidate
    sw = 8'h66;
    step(5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("rs_swdr", {16'h0, bus.swdr}, 32'h0);
    check("rs_rdy", {31'h0, bus.swsr[RDY]}, 32'h0);
    q.push_back(16'h0066);
    wait_commit("rs_66", 30);
    read_pulse();

    // 6: interrupt enable and irq timing
    bus.wr_data = 16'h4000;
    bus.wr_sr   = 1'b1;
    step(1);
    bus.wr_sr   = 1'b0;
    bus.wr_data = 16'h0;
    sw = 8'h55;
    q.push_back(16'h0055);
    wait_commit("t6_55", 30);
    check("t6_rdy", {31'h0, bus.swsr[RDY]}, 32'h1);
    check("t6_irq_lag", {31'h0, bus.irq}, 32'h0);
    step(1);
`ifdef SW_IRQ_EN
    check("t6_ie", {31'h0, bus.swsr[IE]}, 32'h1);
    check("t6_irq", {31'h0, bus.irq}, 32'h1);
    read_pulse();
    check("t6_rd_rdy", {31'h0, bus.swsr[RDY]}, 32'h0);
    check("t6_irq_hold", {31'h0, bus.irq}, 32'h1);
    step(1);
    check("t6_irq_off", {31'h0, bus.irq}, 32'h0);
`else
    check("t6_ie", {31'h0, bus.swsr[IE]}, 32'h0);
    check("t6_irq", {31'h0, bus.irq}, 32'h0);
    read_pulse();
    check("t6_rd_rdy", {31'h0, bus.swsr[RDY]}, 32'h0);
    check("t6_irq_off", {31'h0, bus.irq}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
